// File: rtl/fractal_dispatcher.sv
// fractal_dispatcher: raster-order pixel scheduler for the fractal core bank with a valid/ready result stream.
// Defining DISPATCH_PERF_EN adds the perf_cycles_o/perf_pixels_o frame counters.
module fractal_dispatcher #(
  parameter int INTEGER_BITS    = 8,
  parameter int FRACTIONAL_BITS = 24,
  parameter int MAX_ITER_WIDTH  = 16,
  parameter int CORE_COUNT      = 20,
  parameter int COORD_WIDTH     = 12,
  localparam int DATA_WIDTH     = INTEGER_BITS + FRACTIONAL_BITS
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 frame_start_i,
  input  logic                                 abort_i,
  input  logic [COORD_WIDTH-1:0]               width_i,
  input  logic [COORD_WIDTH-1:0]               height_i,
  input  logic signed [DATA_WIDTH-1:0]         x_base_i,
  input  logic signed [DATA_WIDTH-1:0]         y_base_i,
  input  logic signed [DATA_WIDTH-1:0]         step_i,
  output logic                                 busy_o,
  output logic                                 frame_done_o,
  output logic [CORE_COUNT-1:0]                core_rst_o,
  output logic [CORE_COUNT-1:0]                core_start_o,
  output logic [DATA_WIDTH*CORE_COUNT-1:0]     core_x0_o,
  output logic [DATA_WIDTH*CORE_COUNT-1:0]     core_y0_o,
  input  logic [MAX_ITER_WIDTH*CORE_COUNT-1:0] core_iter_i,
  input  logic [CORE_COUNT-1:0]                core_done_i,
  output logic                                 res_valid_o,
  input  logic                                 res_ready_i,
  output logic [COORD_WIDTH-1:0]               res_px_o,
  output logic [COORD_WIDTH-1:0]               res_py_o,
  output logic [MAX_ITER_WIDTH-1:0]            res_iter_o
`ifdef DISPATCH_PERF_EN
  ,
  output logic [31:0]                          perf_cycles_o,
  output logic [31:0]                          perf_pixels_o
`endif
);
  localparam int IDXW = CORE_COUNT > 1 ? $clog2(CORE_COUNT) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic [COORD_WIDTH-1:0] width_r, height_r, px, py, ipx, ipy, iw, ih, px_nx, py_nx;
  logic signed [DATA_WIDTH-1:0] x_base_r, step_r, x_cur, y_cur, ix, iy, ixb, ist, x_nx, y_nx;
  logic [CORE_COUNT-1:0] busy, armed, col_cand, issue_oh, col_oh;
  logic [IDXW-1:0] issue_idx, col_idx;
  logic issue_found, col_found, start_ok, nonzero, abort_ok, issue_go, collect;
  logic last_px, wrap, drain_exit, zero_done;
  logic [COORD_WIDTH-1:0] tag_x [CORE_COUNT];
  logic [COORD_WIDTH-1:0] tag_y [CORE_COUNT];
  // The first pixel is issued in the accepting IDLE cycle straight from the inputs.
  always_comb begin
    start_ok   = state == IDLE && frame_start_i;
    nonzero    = width_i != '0 && height_i != '0;
    abort_ok   = abort_i && state != IDLE;
    ipx        = start_ok ? '0 : px;
    ipy        = start_ok ? '0 : py;
    iw         = start_ok ? width_i : width_r;
    ih         = start_ok ? height_i : height_r;
    ix         = start_ok ? x_base_i : x_cur;
    iy         = start_ok ? y_base_i : y_cur;
    ixb        = start_ok ? x_base_i : x_base_r;
    ist        = start_ok ? step_i : step_r;
    wrap       = ipx == iw - 1'b1;
    last_px    = wrap && ipy == ih - 1'b1;
    px_nx      = wrap ? '0 : ipx + 1'b1;
    py_nx      = wrap ? ipy + 1'b1 : ipy;
    x_nx       = wrap ? ixb : ix + ist;
    y_nx       = wrap ? iy + ist : iy;
    col_cand   = busy & armed & core_done_i;
    issue_go   = issue_found && ((start_ok && nonzero) || (state == RUN && !abort_i));
    collect    = col_found && (!res_valid_o || res_ready_i) && !abort_ok;
    issue_oh   = issue_go ? (CORE_COUNT'(1) << issue_idx) : '0;
    col_oh     = collect ? (CORE_COUNT'(1) << col_idx) : '0;
    drain_exit = state == DRAIN && !abort_i && busy == '0 && !res_valid_o;
    state_nx   = abort_ok ? IDLE :
                 state == IDLE ? (start_ok && nonzero ? (last_px ? DRAIN : RUN) : IDLE) :
                 state == RUN ? (issue_go && last_px ? DRAIN : RUN) :
                 (drain_exit || state != DRAIN ? IDLE : DRAIN);
  end
  always_comb begin
    issue_idx   = '0;
    issue_found = 1'b0;
    col_idx     = '0;
    col_found   = 1'b0;
    for (int i = CORE_COUNT - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        issue_idx   = IDXW'(i);
        issue_found = 1'b1;
      end
      if (col_cand[i]) begin
        col_idx   = IDXW'(i);
        col_found = 1'b1;
      end
    end
  end
  assign busy_o       = state != IDLE || zero_done;
  assign frame_done_o = drain_exit || zero_done;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      width_r      <= '0;
      height_r     <= '0;
      x_base_r     <= '0;
      step_r       <= '0;
      px           <= '0;
      py           <= '0;
      x_cur        <= '0;
      y_cur        <= '0;
      busy         <= '0;
      armed        <= '0;
      zero_done    <= 1'b0;
      core_rst_o   <= '1;
      core_start_o <= '0;
      core_x0_o    <= '0;
      core_y0_o    <= '0;
      res_valid_o  <= 1'b0;
      res_px_o     <= '0;
      res_py_o     <= '0;
      res_iter_o   <= '0;
    end else begin
      state        <= state_nx;
      zero_done    <= start_ok && !nonzero;
      core_rst_o   <= {CORE_COUNT{abort_ok}};
      core_start_o <= issue_oh;
      busy         <= abort_ok ? '0 : (busy | issue_oh) & ~col_oh;
      // A core arms only after its done line is seen low, so a stale level from the previous job is ignored.
      armed        <= abort_ok ? '0 : (armed | (busy & ~core_done_i)) & ~issue_oh & ~col_oh;
      if (start_ok) begin
        width_r  <= width_i;
        height_r <= height_i;
        x_base_r <= x_base_i;
        step_r   <= step_i;
      end
      if (issue_go) begin
        px    <= px_nx;
        py    <= py_nx;
        x_cur <= x_nx;
        y_cur <= y_nx;
        core_x0_o[issue_idx*DATA_WIDTH +: DATA_WIDTH] <= ix;
        core_y0_o[issue_idx*DATA_WIDTH +: DATA_WIDTH] <= iy;
      end
      if (abort_ok) res_valid_o <= 1'b0;
      else if (collect) begin
        res_valid_o <= 1'b1;
        res_px_o    <= tag_x[col_idx];
        res_py_o    <= tag_y[col_idx];
        res_iter_o  <= core_iter_i[col_idx*MAX_ITER_WIDTH +: MAX_ITER_WIDTH];
      end else if (res_ready_i) res_valid_o <= 1'b0;
    end
  end
  always_ff @(posedge clk_i) begin
    if (issue_go) begin
      tag_x[issue_idx] <= ipx;
      tag_y[issue_idx] <= ipy;
    end
  end
`ifdef DISPATCH_PERF_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_cycles_o <= '0;
      perf_pixels_o <= '0;
    end else begin
      perf_cycles_o <= start_ok ? '0 : perf_cycles_o + 32'(busy_o);
      perf_pixels_o <= start_ok ? '0 : perf_pixels_o + 32'(res_valid_o && res_ready_i);
    end
  end
`endif
endmodule

// File: tb/tb_fractal_dispatcher.sv
// tb_fractal_dispatcher: randomized frames against a pixel-grid scoreboard with a latency-modelled core bank.
module tb_fractal_dispatcher;
  localparam int DW = 32, IW = 16, CC = 20, CW = 12;
  logic clk_i = 0, rst_ni = 0, frame_start_i = 0, abort_i = 0, res_ready_i = 1;
  logic [CW-1:0] width_i = 0, height_i = 0;
  logic signed [DW-1:0] x_base_i = 0, y_base_i = 0, step_i = 0;
  logic busy_o, frame_done_o, res_valid_o;
  logic [CC-1:0] core_rst_o, core_start_o;
  logic [CC-1:0] core_done_i = '0;
  logic [DW*CC-1:0] core_x0_o, core_y0_o;
  logic [IW*CC-1:0] core_iter_i = '0;
  logic [CW-1:0] res_px_o, res_py_o;
  logic [IW-1:0] res_iter_o;
`ifdef DISPATCH_PERF_EN
  logic [31:0] perf_cycles_o, perf_pixels_o;
`endif

  fractal_dispatcher dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .frame_start_i(frame_start_i), .abort_i(abort_i),
    .width_i(width_i), .height_i(height_i), .x_base_i(x_base_i), .y_base_i(y_base_i), .step_i(step_i),
    .busy_o(busy_o), .frame_done_o(frame_done_o), .core_rst_o(core_rst_o), .core_start_o(core_start_o),
    .core_x0_o(core_x0_o), .core_y0_o(core_y0_o), .core_iter_i(core_iter_i), .core_done_i(core_done_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_px_o(res_px_o), .res_py_o(res_py_o),
    .res_iter_o(res_iter_o)
`ifdef DISPATCH_PERF_EN
    , .perf_cycles_o(perf_cycles_o), .perf_pixels_o(perf_pixels_o)
`endif
  );

  initial forever #5 clk_i = ~clk_i;

  typedef struct {int px; int py; logic [IW-1:0] it;} res_t;
  res_t got[$];
  int n_checks = 0, n_fail = 0;
  int ready_mode = 0, lat_min = 3, lat_max = 3, stale_cyc = 0;
  int done_cnt = 0, start_cnt = 0, d_base = 0, s_base = 0;
  int f_w, f_h;
  logic signed [DW-1:0] f_xb, f_yb, f_st;

  function automatic logic [IW-1:0] hash(input logic [31:0] x, input logic [31:0] y);
    return x[31:16] ^ (y[31:16] * 16'd7 + y[15:0]);
  endfunction

  // Core bank model: done stays at its old level for stale_cyc cycles, drops low for a random latency, then rises with the result.
  int m_pend[CC], m_st[CC], m_lo[CC];
  logic [IW-1:0] m_new[CC];
  always @(posedge clk_i) begin
    for (int i = 0; i < CC; i++) begin
      if (core_rst_o[i]) begin
        m_pend[i] <= 0;
        core_done_i[i] <= 1'b0;
      end else if (core_start_o[i]) begin
        m_pend[i] <= 1;
        m_st[i] <= stale_cyc;
        m_lo[i] <= $urandom_range(lat_max, lat_min);
        m_new[i] <= hash(core_x0_o[i*DW +: DW], core_y0_o[i*DW +: DW]);
      end else if (m_pend[i] != 0) begin
        if (m_st[i] > 0) m_st[i] <= m_st[i] - 1;
        else if (m_lo[i] > 0) begin
          core_done_i[i] <= 1'b0;
          m_lo[i] <= m_lo[i] - 1;
        end else begin
          core_done_i[i] <= 1'b1;
          core_iter_i[i*IW +: IW] <= m_new[i];
          m_pend[i] <= 0;
        end
      end
    end
  end

  initial forever begin
    @(posedge clk_i);
    #1;
    res_ready_i = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? ($urandom_range(3, 0) != 0) : 1'b0;
  end

  // Stream monitor: records accepted results, checks held outputs, counts starts and frame_done pulses.
  initial begin
    logic pv, pr;
    logic [CW-1:0] ppx, ppy;
    logic [IW-1:0] pit;
    pv = 0; pr = 0; ppx = 0; ppy = 0; pit = 0;
    forever begin
      @(negedge clk_i);
      if (rst_ni) begin
        if (pv && !pr) begin
          n_checks++;
          if (res_valid_o !== 1'b1 || res_px_o !== ppx || res_py_o !== ppy || res_iter_o !== pit) begin
            n_fail++;
            $display("FAIL hold_stable: got valid=%0b px=%0d py=%0d iter=%h, required valid=1 px=%0d py=%0d iter=%h",
                     res_valid_o, res_px_o, res_py_o, res_iter_o, ppx, ppy, pit);
          end
        end
        if (res_valid_o && res_ready_i) got.push_back('{px: int'(res_px_o), py: int'(res_py_o), it: res_iter_o});
        if (frame_done_o) begin
          done_cnt++;
          n_checks++;
          if (busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_at_done: got busy=%0b, required 1", busy_o);
          end
        end
        start_cnt += $countones(core_start_o);
        n_checks++;
        if ($countones(core_start_o) > 1) begin
          n_fail++;
          $display("FAIL start_onehot: got core_start=%h, required at most one bit", core_start_o);
        end
      end
      pv = res_valid_o; pr = res_ready_i; ppx = res_px_o; ppy = res_py_o; pit = res_iter_o;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion, required end of test");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic start_frame(input int w, input int h, input logic signed [DW-1:0] xb, yb, st);
    @(posedge clk_i);
    #1;
    f_w = w; f_h = h; f_xb = xb; f_yb = yb; f_st = st;
    d_base = done_cnt; s_base = start_cnt;
    got.delete();
    width_i = CW'(w); height_i = CW'(h); x_base_i = xb; y_base_i = yb; step_i = st;
    frame_start_i = 1;
    @(posedge clk_i);
    #1;
    frame_start_i = 0;
    width_i = CW'($urandom); height_i = CW'($urandom);
    x_base_i = $urandom; y_base_i = $urandom; step_i = $urandom;
  endtask

  task automatic finish_frame(input int budget);
    int k;
    bit seen[int];
    logic [DW-1:0] ex, ey;
    k = 0;
    do begin
      @(negedge clk_i);
      k++;
    end while (!frame_done_o && k < budget);
    n_checks++;
    if (!frame_done_o) begin
      n_fail++;
      $display("FAIL frame_done_timeout: got no frame_done in %0d cycles, required a pulse", budget);
      return;
    end
    n_checks++;
    if (got.size() != f_w * f_h) begin
      n_fail++;
      $display("FAIL result_count: got %0d results, required %0d", got.size(), f_w * f_h);
    end
    foreach (got[j]) begin
      ex = f_xb + f_st * got[j].px;
      ey = f_yb + f_st * got[j].py;
      n_checks++;
      if (got[j].px >= f_w || got[j].py >= f_h || seen.exists(got[j].py * 4096 + got[j].px) ||
          got[j].it !== hash(ex, ey)) begin
        n_fail++;
        $display("FAIL result_tag: got px=%0d py=%0d iter=%h dup=%0b, required unique tag in %0dx%0d with iter=%h",
                 got[j].px, got[j].py, got[j].it, seen.exists(got[j].py * 4096 + got[j].px), f_w, f_h, hash(ex, ey));
      end
      seen[got[j].py * 4096 + got[j].px] = 1;
    end
    repeat (4) @(negedge clk_i);
    n_checks++;
    if (done_cnt != d_base + 1 || busy_o !== 1'b0 || res_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_end: got done_pulses=%0d busy=%0b valid=%0b, required 1 0 0",
               done_cnt - d_base, busy_o, res_valid_o);
    end
  endtask

  task automatic test_reset();
    rst_ni = 0;
    repeat (3) @(negedge clk_i);
    n_checks++;
    if (core_rst_o !== '1 || busy_o !== 0 || frame_done_o !== 0 || res_valid_o !== 0 || core_start_o !== 0 || core_x0_o !== 0) begin
      n_fail++;
      $display("FAIL reset_values: got core_rst=%h busy=%0b done=%0b valid=%0b start=%h, required all-ones 0 0 0 0",
               core_rst_o, busy_o, frame_done_o, res_valid_o, core_start_o);
    end
    @(posedge clk_i);
    #1;
    rst_ni = 1;
    @(negedge clk_i);
    n_checks++;
    if (core_rst_o !== '1) begin
      n_fail++;
      $display("FAIL reset_rst_hold: got core_rst=%h, required all ones", core_rst_o);
    end
    @(negedge clk_i);
    n_checks++;
    if (core_rst_o !== '0) begin
      n_fail++;
      $display("FAIL reset_rst_release: got core_rst=%h, required 0", core_rst_o);
    end
  endtask

  task automatic test_basic();
    ready_mode = 0; lat_min = 5; lat_max = 5;
    start_frame(4, 2, 32'shFE000000, 32'shFF000000, 32'sh00800000);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk_i);
      n_checks++;
      if (core_start_o !== (CC'(1) << (c - 1)) || busy_o !== 1'b1) begin
        n_fail++;
        $display("FAIL start_sequence: cycle %0d got start=%h busy=%0b, required %h 1", c, core_start_o, busy_o, CC'(1) << (c - 1));
      end
      if (c == 6) begin
        n_checks++;
        if (core_x0_o[5*DW +: DW] !== 32'hFE800000 || core_y0_o[5*DW +: DW] !== 32'hFF800000) begin
          n_fail++;
          $display("FAIL core5_coord: got x0=%h y0=%h, required fe800000 ff800000",
                   core_x0_o[5*DW +: DW], core_y0_o[5*DW +: DW]);
        end
      end
    end
    finish_frame(2000);
  endtask

  task automatic test_random_frames();
    ready_mode = 1; lat_min = 1; lat_max = 30;
    start_frame(6, 5, $urandom, $urandom, $urandom);
    finish_frame(5000);
    start_frame(1, 1, $urandom, $urandom, $urandom);
    finish_frame(2000);
    for (int n = 0; n < 4; n++) begin
      start_frame($urandom_range(7, 1), $urandom_range(6, 1), $urandom, $urandom, $urandom);
      finish_frame(5000);
    end
  endtask

  task automatic test_backpressure();
    ready_mode = 0; lat_min = 2; lat_max = 6;
    start_frame(8, 4, $urandom, $urandom, $urandom);
    cyc(10);
    ready_mode = 2;
    cyc(21);
    @(negedge clk_i);
    n_checks++;
    if (res_valid_o !== 1'b1 || res_ready_i !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_hold: got valid=%0b ready=%0b, required 1 0", res_valid_o, res_ready_i);
    end
    ready_mode = 0;
    finish_frame(5000);
  endtask

  task automatic test_stale_done();
    ready_mode = 1; lat_min = 1; lat_max = 4; stale_cyc = 2;
    start_frame(10, 5, $urandom, $urandom, $urandom);
    finish_frame(5000);
    stale_cyc = 0;
  endtask

  task automatic test_abort();
    logic signed [DW-1:0] xb;
    ready_mode = 0; lat_min = 20; lat_max = 20;
    start_frame(5, 5, $urandom, $urandom, $urandom);
    cyc(2);
    abort_i = 1;
    cyc(1);
    abort_i = 0;
    @(negedge clk_i);
    n_checks++;
    if (core_rst_o !== '1 || busy_o !== 0 || res_valid_o !== 0 || core_start_o !== 0) begin
      n_fail++;
      $display("FAIL abort_pulse: got core_rst=%h busy=%0b valid=%0b start=%h, required all-ones 0 0 0",
               core_rst_o, busy_o, res_valid_o, core_start_o);
    end
    @(negedge clk_i);
    n_checks++;
    if (core_rst_o !== '0) begin
      n_fail++;
      $display("FAIL abort_release: got core_rst=%h, required 0", core_rst_o);
    end
    repeat (3) @(negedge clk_i);
    n_checks++;
    if (start_cnt - s_base != 3 || done_cnt != d_base || got.size() != 0) begin
      n_fail++;
      $display("FAIL abort_effect: got starts=%0d done_pulses=%0d results=%0d, required 3 0 0",
               start_cnt - s_base, done_cnt - d_base, got.size());
    end
    lat_min = 2; lat_max = 5;
    xb = $urandom;
    start_frame(3, 2, xb, $urandom, $urandom);
    @(negedge clk_i);
    n_checks++;
    if (core_start_o !== CC'(1) || core_x0_o[DW-1:0] !== xb) begin
      n_fail++;
      $display("FAIL abort_restart: got start=%h x0=%h, required 1 %h", core_start_o, core_x0_o[DW-1:0], xb);
    end
    finish_frame(2000);
  endtask

  task automatic test_zero_size();
    for (int n = 0; n < 2; n++) begin
      start_frame(n == 0 ? 0 : 7, n == 0 ? 5 : 0, $urandom, $urandom, $urandom);
      @(negedge clk_i);
      n_checks++;
      if (frame_done_o !== 1'b1) begin
        n_fail++;
        $display("FAIL zero_done: got frame_done=%0b at cycle 1, required 1", frame_done_o);
      end
      repeat (10) begin
        @(negedge clk_i);
        n_checks++;
        if (core_start_o !== '0 || res_valid_o !== 0 || frame_done_o !== 0) begin
          n_fail++;
          $display("FAIL zero_quiet: got start=%h valid=%0b done=%0b, required 0 0 0", core_start_o, res_valid_o, frame_done_o);
        end
      end
      n_checks++;
      if (done_cnt != d_base + 1 || start_cnt != s_base) begin
        n_fail++;
        $display("FAIL zero_counts: got done_pulses=%0d starts=%0d, required 1 0", done_cnt - d_base, start_cnt - s_base);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random_frames();
    test_backpressure();
    test_stale_done();
    test_abort();
    test_zero_size();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
